trap_ctrl: RTL

- Machine-mode trap sequencer in the WB stage, beside the CSR file.
- Watches the instruction committing in WB for synchronous exceptions, mret and pending interrupts.
- Sequences the trap CSR updates (mepc/mcause/mtval/mstatus) over a fixed 3-state FSM.
- Flushes and stalls the pipeline, then redirects fetch to the mtvec-derived handler or to mepc.

---
 rtl/trap_ctrl_pkg.sv | 30 +++
 rtl/trap_ctrl_cause_enc.sv | 70 +++++++
 rtl/trap_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared encodings for the machine-mode trap sequencer: cause codes, mtvec modes,
// FSM states and the kind of event being sequenced.
package trap_ctrl_pkg;

  localparam logic [4:0] MCAUSE_INSTR_MISALIGNED = 5'd0;
  localparam logic [4:0] MCAUSE_ILLEGAL_INSTR    = 5'd2;
  localparam logic [4:0] MCAUSE_BREAKPOINT       = 5'd3;
  localparam logic [4:0] MCAUSE_ECALL_M          = 5'd11;

  localparam logic [4:0] MCAUSE_IRQ_M_SW         = 5'd3;
  localparam logic [4:0] MCAUSE_IRQ_M_TIMER      = 5'd7;
  localparam logic [4:0] MCAUSE_IRQ_M_EXT        = 5'd11;

  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAVE,
    ST_REDIRECT
  } trap_state_e;

  typedef enum logic [1:0] {
    KIND_NONE,
    KIND_EXC,
    KIND_IRQ,
    KIND_MRET
  } trap_kind_e;

endpackage

// File: rtl/trap_ctrl_cause_enc.sv
// Priority encoder for the instruction in WB: picks the single event to sequence
// (exception > mret > interrupt) and produces its mcause/mtval values.
module trap_ctrl_cause_enc
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit MTVAL_ILL_EN = 1'b1
) (
  input  logic            wb_valid,
  input  logic [XLEN-1:0] wb_pc,
  input  logic [XLEN-1:0] wb_instruction,
  input  logic            wb_ill_instr,
  input  logic            wb_exc_instr_addr_misaligned,
  input  logic [XLEN-1:0] wb_exc_addr,
  input  logic            wb_ecall,
  input  logic            wb_ebreak,
  input  logic            wb_mret,
  input  logic            irq_ext,
  input  logic            irq_sw,
  input  logic            irq_timer,
  input  logic            mstatus_mie,
  output logic            evt_valid,
  output trap_kind_e      evt_kind,
  output logic [XLEN-1:0] evt_cause,
  output logic [XLEN-1:0] evt_tval
);

  function automatic logic [XLEN-1:0] exc_cause(input logic [4:0] code);
    return {{(XLEN-5){1'b0}}, code};
  endfunction

  function automatic logic [XLEN-1:0] irq_cause(input logic [4:0] code);
    return {1'b1, {(XLEN-6){1'b0}}, code};
  endfunction

  always_comb begin
    // NOTE: every output gets a default first so no path through the if-chain infers a latch.
    evt_kind  = KIND_NONE;
    evt_cause = '0;
    evt_tval  = '0;
    if (wb_valid) begin
      if (wb_exc_instr_addr_misaligned) begin
        evt_kind  = KIND_EXC;
        evt_cause = exc_cause(MCAUSE_INSTR_MISALIGNED);
        evt_tval  = wb_exc_addr;
      end else if (wb_ill_instr) begin
        evt_kind  = KIND_EXC;
        evt_cause = exc_cause(MCAUSE_ILLEGAL_INSTR);
        evt_tval  = MTVAL_ILL_EN ? wb_instruction : '0;
      end else if (wb_ebreak) begin
        evt_kind  = KIND_EXC;
        evt_cause = exc_cause(MCAUSE_BREAKPOINT);
        evt_tval  = wb_pc;
      end else if (wb_ecall) begin
        evt_kind  = KIND_EXC;
        evt_cause = exc_cause(MCAUSE_ECALL_M);
      end else if (wb_mret) begin
        evt_kind  = KIND_MRET;
      end else if (mstatus_mie && (irq_ext || irq_sw || irq_timer)) begin
        // An exception or mret in WB defers the interrupt; it is still pending next time.
        evt_kind  = KIND_IRQ;
        evt_cause = irq_ext ? irq_cause(MCAUSE_IRQ_M_EXT) :
                    irq_sw  ? irq_cause(MCAUSE_IRQ_M_SW)  :
                              irq_cause(MCAUSE_IRQ_M_TIMER);
      end
    end
    evt_valid = (evt_kind != KIND_NONE);
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer in WB: detects a trap or mret, drives the CSR update,
// flushes/stalls the pipeline and redirects fetch two cycles after detection.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit MTVAL_ILL_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  input  logic [XLEN-1:0] wb_pc,
  input  logic [XLEN-1:0] wb_instruction,
  input  logic            wb_ill_instr,
  input  logic            wb_exc_instr_addr_misaligned,
  input  logic [XLEN-1:0] wb_exc_addr,
  input  logic            wb_ecall,
  input  logic            wb_ebreak,
  input  logic            wb_mret,
  input  logic            irq_ext,
  input  logic            irq_sw,
  input  logic            irq_timer,
  input  logic            mstatus_mie,
  input  logic            mstatus_mpie,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic            csr_trap_wen,
  output logic            csr_mret_wen,
  output logic [XLEN-1:0] trap_mepc,
  output logic [XLEN-1:0] trap_mcause,
  output logic [XLEN-1:0] trap_mtval,
  output logic            wb_kill,
  output logic            trap_flush,
  output logic            trap_stall,
  output logic            pc_redirect,
  output logic [XLEN-1:0] pc_target
);

  trap_state_e     state;
  trap_kind_e      kind_q;
  logic            flush_q;
  logic            detect;
  logic            evt_valid;
  trap_kind_e      evt_kind;
  logic [XLEN-1:0] evt_cause;
  logic [XLEN-1:0] evt_tval;
  logic [XLEN-1:0] tvec_base;
  logic            unused_mpie;

  // The CSR file applies mpie<=mie itself; this block never needs the old mpie.
  assign unused_mpie = mstatus_mpie;

  trap_ctrl_cause_enc #(
    .XLEN         (XLEN),
    .MTVAL_ILL_EN (MTVAL_ILL_EN)
  ) u_cause_enc (
    .wb_valid                     (wb_valid),
    .wb_pc                        (wb_pc),
    .wb_instruction               (wb_instruction),
    .wb_ill_instr                 (wb_ill_instr),
    .wb_exc_instr_addr_misaligned (wb_exc_instr_addr_misaligned),
    .wb_exc_addr                  (wb_exc_addr),
    .wb_ecall                     (wb_ecall),
    .wb_ebreak                    (wb_ebreak),
    .wb_mret                      (wb_mret),
    .irq_ext                      (irq_ext),
    .irq_sw                       (irq_sw),
    .irq_timer                    (irq_timer),
    .mstatus_mie                  (mstatus_mie),
    .evt_valid                    (evt_valid),
    .evt_kind                     (evt_kind),
    .evt_cause                    (evt_cause),
    .evt_tval                     (evt_tval)
  );

  // Detection is combinational in cycle N; gating with rst keeps every output low during reset.
  assign detect     = rst && (state == ST_IDLE) && evt_valid;
  assign wb_kill    = detect && (evt_kind != KIND_MRET);
  assign trap_flush = detect || flush_q;

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state        <= ST_IDLE;
      kind_q       <= KIND_NONE;
      trap_mepc    <= '0;
      trap_mcause  <= '0;
      trap_mtval   <= '0;
      csr_trap_wen <= 1'b0;
      csr_mret_wen <= 1'b0;
      trap_stall   <= 1'b0;
      pc_redirect  <= 1'b0;
      flush_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (detect) begin
            state        <= ST_SAVE;
            kind_q       <= evt_kind;
            trap_mepc    <= wb_pc;
            trap_mcause  <= evt_cause;
            trap_mtval   <= evt_tval;
            csr_trap_wen <= (evt_kind != KIND_MRET);
            csr_mret_wen <= (evt_kind == KIND_MRET);
            trap_stall   <= 1'b1;
            flush_q      <= 1'b1;
          end
        end
        ST_SAVE: begin
          state        <= ST_REDIRECT;
          csr_trap_wen <= 1'b0;
          csr_mret_wen <= 1'b0;
          trap_stall   <= 1'b0;
          pc_redirect  <= 1'b1;
        end
        ST_REDIRECT: begin
          state       <= ST_IDLE;
          pc_redirect <= 1'b0;
          flush_q     <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // mtvec/mepc are read live in REDIRECT so a CSR write made in SAVE is already visible.
  always_comb begin
    tvec_base = {mtvec[XLEN-1:2], 2'b00};
    pc_target = '0;
    if (pc_redirect) begin
      if (kind_q == KIND_MRET)
        pc_target = mepc;
      else if ((mtvec[1:0] == MTVEC_MODE_VECTORED) && (kind_q == KIND_IRQ))
        pc_target = tvec_base + {{(XLEN-7){1'b0}}, trap_mcause[4:0], 2'b00};
      else
        pc_target = tvec_base;
    end
  end

endmodule
